// File: rtl/nfi_scheduler.sv
// Paces generations of a field iterator: counts enabled cycles at a selectable
// speed, issues a one-cycle go pulse, and waits for the iterator's done pulse.
module nfi_scheduler #(
  parameter int BASE_PERIOD = 4,
  parameter int NUM_SPEEDS  = 4,
  parameter int INIT_SPEED  = 0,
  parameter int GEN_W       = 16,
  localparam int SPD_W      = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
  localparam int CNT_W      = $clog2(BASE_PERIOD << (NUM_SPEEDS - 1))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_toggle_pause,
  input  logic             i_cmd_step,
  input  logic             i_cmd_speed_up,
  input  logic             i_cmd_speed_down,
  input  logic             i_NFI_allowed,
  input  logic             i_NFI_done,
  output logic             o_go,
  output logic             o_busy,
  output logic             o_paused,
  output logic [SPD_W-1:0] o_speed,
  output logic [GEN_W-1:0] o_gen_cnt
);

  localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(NUM_SPEEDS - 1);
  localparam logic [SPD_W-1:0] RST_SPD = SPD_W'(INIT_SPEED);

  typedef enum logic {ST_COUNT = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           state_q;
  logic             tog_prev_q, step_prev_q, up_prev_q, dn_prev_q;
  logic             tog_e_q, step_e_q, up_e_q, dn_e_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_last;
  logic             paused_q;
  logic             step_pend_q, step_pend_d;
  logic             go_q, busy_q;
  logic [SPD_W-1:0] speed_q, speed_d;
  logic [GEN_W-1:0] gen_q;
  logic             advance, period_hit, step_fire, unpause, spd_chg;

  // Terminal count for a speed level: the slowest level has the longest period.
  function automatic logic [CNT_W-1:0] last_count(input logic [SPD_W-1:0] s);
    int unsigned sh;
    sh = 32'(NUM_SPEEDS - 1) - 32'(s);
    return CNT_W'((BASE_PERIOD << sh) - 1);
  endfunction

  assign cnt_last = last_count(speed_q);

  always_comb begin
    advance     = !paused_q && i_NFI_allowed;
    period_hit  = (state_q == ST_COUNT) && advance && (cnt_q == cnt_last);
    unpause     = tog_e_q && paused_q;
    // A toggle in the same cycle wins over a pending step.
    step_fire   = (state_q == ST_COUNT) && paused_q && !tog_e_q &&
                  step_pend_q && i_NFI_allowed;
    speed_d     = speed_q;
    if (up_e_q && !dn_e_q && (speed_q != MAX_SPD)) begin
      speed_d = speed_q + 1'b1;
    end else if (dn_e_q && !up_e_q && (speed_q != '0)) begin
      speed_d = speed_q - 1'b1;
    end
    spd_chg     = (speed_d != speed_q);
    step_pend_d = step_pend_q;
    if (unpause) begin
      step_pend_d = 1'b0;
    end else if (paused_q && step_e_q) begin
      step_pend_d = 1'b1;
    end else if (step_fire) begin
      step_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COUNT;
      tog_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
      dn_prev_q   <= 1'b0;
      tog_e_q     <= 1'b0;
      step_e_q    <= 1'b0;
      up_e_q      <= 1'b0;
      dn_e_q      <= 1'b0;
      cnt_q       <= '0;
      paused_q    <= 1'b0;
      step_pend_q <= 1'b0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      speed_q     <= RST_SPD;
      gen_q       <= '0;
    end else begin
      tog_prev_q  <= i_cmd_toggle_pause;
      step_prev_q <= i_cmd_step;
      up_prev_q   <= i_cmd_speed_up;
      dn_prev_q   <= i_cmd_speed_down;
      tog_e_q     <= i_cmd_toggle_pause & ~tog_prev_q;
      step_e_q    <= i_cmd_step & ~step_prev_q;
      up_e_q      <= i_cmd_speed_up & ~up_prev_q;
      dn_e_q      <= i_cmd_speed_down & ~dn_prev_q;
      go_q        <= 1'b0;
      step_pend_q <= step_pend_d;
      speed_q     <= speed_d;
      if (tog_e_q) begin
        paused_q <= ~paused_q;
      end
      case (state_q)
        ST_COUNT: begin
          if (period_hit || step_fire) begin
            cnt_q   <= '0;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end else if (spd_chg) begin
            cnt_q <= '0;
          end else if (advance) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_BUSY: begin
          if (spd_chg) begin
            cnt_q <= '0;
          end
          if (i_NFI_done) begin
            gen_q   <= gen_q + 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_COUNT;
          end
        end
      endcase
    end
  end

  assign o_go      = go_q;
  assign o_busy    = busy_q;
  assign o_paused  = paused_q;
  assign o_speed   = speed_q;
  assign o_gen_cnt = gen_q;

endmodule

// File: tb/tb_nfi_scheduler.sv
// Bench for nfi_scheduler: speed table plus hand sequences for pause, step,
// gated counting, done handling, counter wrap and asynchronous reset.
module tb_nfi_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_tog = 1'b0, cmd_step = 1'b0, cmd_up = 1'b0, cmd_dn = 1'b0;
  logic        allowed = 1'b0, done = 1'b0;
  logic        go, busy, paused;
  logic [1:0]  speed;
  logic [15:0] gen;
  logic        go2, busy2, paused2;
  logic [1:0]  speed2;
  logic [1:0]  gen2;

  nfi_scheduler dut (
    .clk(clk), .rst(rst),
    .i_cmd_toggle_pause(cmd_tog), .i_cmd_step(cmd_step),
    .i_cmd_speed_up(cmd_up), .i_cmd_speed_down(cmd_dn),
    .i_NFI_allowed(allowed), .i_NFI_done(done),
    .o_go(go), .o_busy(busy), .o_paused(paused),
    .o_speed(speed), .o_gen_cnt(gen)
  );

  // Same stimulus, narrow generation counter to observe wrap-around.
  nfi_scheduler #(.GEN_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .i_cmd_toggle_pause(cmd_tog), .i_cmd_step(cmd_step),
    .i_cmd_speed_up(cmd_up), .i_cmd_speed_down(cmd_dn),
    .i_NFI_allowed(allowed), .i_NFI_done(done),
    .o_go(go2), .o_busy(busy2), .o_paused(paused2),
    .o_speed(speed2), .o_gen_cnt(gen2)
  );

  typedef struct {
    int n_up;
    int n_dn;
    int n_both;
    int exp_speed;
    int exp_period;
  } row_t;

  row_t        rows[8];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_cd = 0;
  int          go_cnt = 0;
  bit          auto_done = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: sample after the edge, score go pulses, emulate the iterator.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    done = 1'b0;
    if (go) begin
      go_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_go: o_go=1 at cycle %0d, required 0", cyc);
      end else begin
        check("go_cycle", cyc, exp_q.pop_front());
      end
      if (auto_done) done_cd = 3;
    end
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) done = 1'b1;
    end
  endtask

  task automatic wait_go(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL go_timeout: %0d go pulses outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_tog = 1'b0; cmd_step = 1'b0; cmd_up = 1'b0; cmd_dn = 1'b0;
    allowed = 1'b0; done = 1'b0; done_cd = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // which: 0 = up, 1 = down, 2 = up and down together
  task automatic pulse(input int which);
    cmd_up = (which != 1);
    cmd_dn = (which != 0);
    tick();
    cmd_up = 1'b0;
    cmd_dn = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, u, a, g0, n;
    rows[0] = '{5, 0, 0, 3, 4};
    rows[1] = '{5, 5, 0, 0, 32};
    rows[2] = '{2, 0, 0, 2, 8};
    rows[3] = '{3, 0, 1, 3, 4};
    rows[4] = '{1, 0, 0, 1, 16};
    rows[5] = '{0, 1, 0, 0, 32};
    rows[6] = '{2, 1, 0, 1, 16};
    rows[7] = '{1, 0, 2, 1, 16};

    do_reset();
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_paused", paused, 0);
    check("rst_speed", speed, 0);
    check("rst_gen", gen, 0);

    // Free running at default speed: period 32 plus 3 busy cycles.
    allowed = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(32 + (k - 1) * 35);
      wait_go(60);
      check("gen_at_go", gen, k - 1);
    end
    repeat (3) tick();
    check("gen_after5", gen, 5);
    check("gen_wrap_w2", gen2, 1);
    check("busy_after_done", busy, 0);
    exp_q.push_back(32 + 5 * 35);
    wait_go(60);
    check("busy_in_flight", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_go", go, 0);
    check("arst_busy", busy, 0);
    check("arst_paused", paused, 0);
    check("arst_speed", speed, 0);
    check("arst_gen", gen, 0);
    check("arst_gen_w2", gen2, 0);
    do_reset();
    allowed = 1'b1;
    exp_q.push_back(32);
    wait_go(60);

    // Two-cycle command latency.
    do_reset();
    cmd_up = 1'b1;
    tick();
    check("speed_lat1", speed, 0);
    tick();
    check("speed_lat2", speed, 1);
    cmd_up = 1'b0;

    // Speed table: commands with counting held off, then two measured periods.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < rows[r].n_up; i++) pulse(0);
      for (int i = 0; i < rows[r].n_dn; i++) pulse(1);
      for (int i = 0; i < rows[r].n_both; i++) pulse(2);
      repeat (2) tick();
      check("tbl_speed", speed, rows[r].exp_speed);
      c = cyc;
      allowed = 1'b1;
      exp_q.push_back(c + rows[r].exp_period);
      exp_q.push_back(c + 2 * rows[r].exp_period + 3);
      wait_go(2 * rows[r].exp_period + 40);
      check("tbl_gen", gen, 1);
    end

    // Pause with the counter at 10, hold 100 cycles, resume for 22 more.
    do_reset();
    allowed = 1'b1;
    repeat (8) tick();
    cmd_tog = 1'b1;
    tick();
    check("pause_lat1", paused, 0);
    cmd_tog = 1'b0;
    tick();
    check("pause_lat2", paused, 1);
    g0 = go_cnt;
    repeat (100) tick();
    check("no_go_paused", go_cnt - g0, 0);
    u = cyc;
    cmd_tog = 1'b1;
    tick();
    cmd_tog = 1'b0;
    tick();
    check("unpaused", paused, 0);
    exp_q.push_back(u + 24);
    wait_go(40);

    // Step while paused, gated by allowed; a second step latched during busy.
    do_reset();
    cmd_tog = 1'b1;
    tick();
    cmd_tog = 1'b0;
    repeat (3) tick();
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    repeat (19) tick();
    check("step_held", busy, 0);
    a = cyc;
    allowed = 1'b1;
    exp_q.push_back(a + 1);
    wait_go(5);
    check("step_busy", busy, 1);
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
    exp_q.push_back(a + 5);
    wait_go(10);
    g0 = go_cnt;
    repeat (40) tick();
    check("step_single", go_cnt - g0, 0);
    check("step_paused", paused, 1);
    check("step_gen", gen, 2);
    u = cyc;
    cmd_tog = 1'b1;
    cmd_step = 1'b1;
    tick();
    cmd_tog = 1'b0;
    cmd_step = 1'b0;
    tick();
    check("tog_step_paused", paused, 0);
    exp_q.push_back(u + 34);
    wait_go(45);

    // Counting gated every other cycle at the fastest speed; stray done in COUNT.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(0);
    repeat (2) tick();
    check("gate_speed", speed, 3);
    c = cyc;
    exp_q.push_back(c + 7);
    allowed = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      allowed = ~allowed;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL gate_timeout: no go within 20 cycles, required 1");
      exp_q.delete();
    end
    allowed = 1'b0;
    repeat (4) tick();
    check("gate_gen", gen, 1);
    check("gate_busy", busy, 0);
    done = 1'b1;
    tick();
    tick();
    check("done_in_count_gen", gen, 1);
    check("done_in_count_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
